// File: rtl/axi_slave_adapter.sv
// AXI4-Lite slave that turns one read or write transaction at a time into a
// simple valid/ready memory request. Every output comes straight from a register.
module axi_slave_adapter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] AWADDR_i,
    input  logic              AWVALID_i,
    output logic              AWREADY_o,
    input  logic [31:0]       WDATA_i,
    input  logic [3:0]        WSTRB_i,
    input  logic              WVALID_i,
    output logic              WREADY_o,
    output logic [1:0]        BRESP_o,
    output logic              BVALID_o,
    input  logic              BREADY_i,
    input  logic [ADDR_W-1:0] ARADDR_i,
    input  logic              ARVALID_i,
    output logic              ARREADY_o,
    output logic [31:0]       RDATA_o,
    output logic [1:0]        RRESP_o,
    output logic              RVALID_o,
    input  logic              RREADY_i,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ADDR   = 3'd1,
        RD_MEM    = 3'd2,
        RD_RESP   = 3'd3,
        WR_ACCEPT = 3'd4,
        WR_MEM    = 3'd5,
        WR_RESP   = 3'd6
    } state_t;

    state_t            state;
    logic              aw_done;
    logic              w_done;
    logic              last_wr;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    // Handshake rule, AXI and memory side alike: a beat transfers on the rising
    // clk_i edge where VALID and READY are both 1; VALID holds its payload
    // stable until that edge, and READY is never a function of VALID.
    logic              aw_fire;
    logic              w_fire;
    logic              aw_next;
    logic              w_next;
    logic [ADDR_W-1:0] awaddr_next;
    logic [31:0]       wdata_next;
    logic [3:0]        wstrb_next;
    logic              wr_req;

    assign aw_fire     = AWVALID_i & AWREADY_o;
    assign w_fire      = WVALID_i & WREADY_o;
    assign aw_next     = aw_done | aw_fire;
    assign w_next      = w_done | w_fire;
    assign awaddr_next = aw_fire ? AWADDR_i : awaddr_q;
    assign wdata_next  = w_fire ? WDATA_i : wdata_q;
    assign wstrb_next  = w_fire ? WSTRB_i : wstrb_q;
    assign wr_req      = AWVALID_i | WVALID_i;

    // The adapter never reports an error.
    assign RRESP_o = 2'b00;
    assign BRESP_o = 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            last_wr     <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            AWREADY_o   <= 1'b0;
            WREADY_o    <= 1'b0;
            BVALID_o    <= 1'b0;
            ARREADY_o   <= 1'b0;
            RDATA_o     <= '0;
            RVALID_o    <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // With both sides pending, last_wr picks whoever was not served last.
                    if (ARVALID_i && (!wr_req || last_wr)) begin
                        ARREADY_o <= 1'b1;
                        state     <= RD_ADDR;
                    end else if (wr_req) begin
                        AWREADY_o <= ~aw_done;
                        WREADY_o  <= ~w_done;
                        state     <= WR_ACCEPT;
                    end
                end

                RD_ADDR: begin
                    ARREADY_o <= 1'b0;
                    if (ARVALID_i) begin
                        mem_addr_o  <= ARADDR_i;
                        mem_wstrb_o <= 4'b0000;
                        mem_valid_o <= 1'b1;
                        state       <= RD_MEM;
                    end else begin
                        state <= IDLE;
                    end
                end

                RD_MEM: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        RDATA_o     <= mem_rdata_i;
                        RVALID_o    <= 1'b1;
                        state       <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (RREADY_i) begin
                        RVALID_o <= 1'b0;
                        last_wr  <= 1'b0;
                        state    <= IDLE;
                    end
                end

                WR_ACCEPT: begin
                    if (aw_fire) begin
                        awaddr_q  <= AWADDR_i;
                        aw_done   <= 1'b1;
                        AWREADY_o <= 1'b0;
                    end
                    if (w_fire) begin
                        wdata_q  <= WDATA_i;
                        wstrb_q  <= WSTRB_i;
                        w_done   <= 1'b1;
                        WREADY_o <= 1'b0;
                    end
                    if (aw_next && w_next) begin
                        AWREADY_o <= 1'b0;
                        WREADY_o  <= 1'b0;
                        // An all-zero strobe writes nothing, so memory is not touched.
                        if (wstrb_next == 4'b0000) begin
                            BVALID_o <= 1'b1;
                            state    <= WR_RESP;
                        end else begin
                            mem_addr_o  <= awaddr_next;
                            mem_wdata_o <= wdata_next;
                            mem_wstrb_o <= wstrb_next;
                            mem_valid_o <= 1'b1;
                            state       <= WR_MEM;
                        end
                    end
                end

                WR_MEM: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        BVALID_o    <= 1'b1;
                        state       <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (BREADY_i) begin
                        BVALID_o <= 1'b0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        last_wr  <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_adapter.sv
// Bench for axi_slave_adapter: AXI driver tasks, a wait-state memory model and
// a scoreboard of expected memory requests and read data.
module tb_axi_slave_adapter;

    localparam int ADDR_W = 32;
    localparam int CLK_P  = 10;

    logic              clk_i;
    logic              rst_i;
    logic [ADDR_W-1:0] AWADDR_i;
    logic              AWVALID_i;
    logic              AWREADY_o;
    logic [31:0]       WDATA_i;
    logic [3:0]        WSTRB_i;
    logic              WVALID_i;
    logic              WREADY_o;
    logic [1:0]        BRESP_o;
    logic              BVALID_o;
    logic              BREADY_i;
    logic [ADDR_W-1:0] ARADDR_i;
    logic              ARVALID_i;
    logic              ARREADY_o;
    logic [31:0]       RDATA_o;
    logic [1:0]        RRESP_o;
    logic              RVALID_o;
    logic              RREADY_i;
    logic              mem_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic              mem_ready_i;
    logic [31:0]       mem_rdata_i;

    axi_slave_adapter #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .AWADDR_i(AWADDR_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
        .BRESP_o(BRESP_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
        .ARADDR_i(ARADDR_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
        .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #(CLK_P/2) clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [67:0] exp_q[$];            // {addr, wdata (0 for reads), wstrb}
    logic [7:0]  order_q[$];
    logic [31:0] mem    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    int          mem_wait          = 0;
    int          mem_valid_cycles  = 0;
    int          mem_done_cnt      = 0;

    task automatic check_eq(input string tag, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 32'h0;
    endfunction

    // ---------------- memory model ----------------
    initial begin
        int          wait_cnt;
        logic [31:0] a;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        wait_cnt    = 0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ready_i = 1'b0;
            mem_rdata_i = $urandom;
            if (!mem_valid_o || rst_i) begin
                wait_cnt = 0;
            end else begin
                mem_valid_cycles++;
                if (exp_q.size() == 0)
                    check_eq("mem_unexpected", 68'd1, 68'd0);
                else
                    check_eq("mem_req", {mem_addr_o, (mem_wstrb_o == 4'h0) ? 32'h0 : mem_wdata_o,
                                         mem_wstrb_o}, exp_q[0]);
                if (wait_cnt >= mem_wait) begin
                    wait_cnt    = 0;
                    mem_ready_i = 1'b1;
                    mem_done_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    a = mem_addr_o;
                    if (mem_wstrb_o == 4'h0)
                        mem_rdata_i = mem.exists(a) ? mem[a] : 32'h0;
                    else
                        mem[a] = merge(mem.exists(a) ? mem[a] : 32'h0, mem_wdata_o, mem_wstrb_o);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input int stall, input bit sb, output int lat);
        time t0;
        bit  ok;
        if (sb) exp_q.push_back({addr, 32'h0, 4'h0});
        ARADDR_i  = addr;
        ARVALID_i = 1'b1;
        t0 = $time;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (ARREADY_o) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("ar_timeout", 68'd0, 68'd1);
        @(posedge clk_i);
        #1;
        ARVALID_i = 1'b0;
        ARADDR_i  = $urandom;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (RVALID_o) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("r_timeout", 68'd0, 68'd1);
        lat = int'(($time - t0) / CLK_P);
        for (int i = 0; i < stall; i++) begin
            check_eq("r_stall_valid", RVALID_o, 1);
            check_eq("r_stall_data", RDATA_o, exp_data);
            check_eq("r_stall_ready", {ARREADY_o, AWREADY_o, WREADY_o}, 3'b000);
            @(negedge clk_i);
        end
        check_eq("rdata", RDATA_o, exp_data);
        check_eq("rresp", RRESP_o, 2'b00);
        RREADY_i = 1'b1;
        @(posedge clk_i);
        #1;
        RREADY_i = 1'b0;
        order_q.push_back("R");
        check_eq("r_drop", RVALID_o, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int stall, input bit sb,
                            output int lat);
        time t0;
        bit  ok;
        if (sb && strb != 4'h0) exp_q.push_back({addr, data, strb});
        shadow[addr] = merge(shadow_rd(addr), data, strb);
        t0 = $time;
        fork
            begin
                bit aw_ok;
                repeat (aw_dly) begin @(posedge clk_i); #1; end
                AWADDR_i  = addr;
                AWVALID_i = 1'b1;
                aw_ok = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk_i);
                    if (AWREADY_o) begin aw_ok = 1'b1; break; end
                end
                if (!aw_ok) check_eq("aw_timeout", 68'd0, 68'd1);
                @(posedge clk_i);
                #1;
                AWVALID_i = 1'b0;
                AWADDR_i  = $urandom;
            end
            begin
                bit w_ok;
                repeat (w_dly) begin @(posedge clk_i); #1; end
                WDATA_i  = data;
                WSTRB_i  = strb;
                WVALID_i = 1'b1;
                w_ok = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk_i);
                    if (WREADY_o) begin w_ok = 1'b1; break; end
                end
                if (!w_ok) check_eq("w_timeout", 68'd0, 68'd1);
                @(posedge clk_i);
                #1;
                WVALID_i = 1'b0;
                WDATA_i  = $urandom;
                WSTRB_i  = $urandom;
            end
        join
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (BVALID_o) begin ok = 1'b1; break; end
        end
        if (!ok) check_eq("b_timeout", 68'd0, 68'd1);
        lat = int'(($time - t0) / CLK_P);
        for (int i = 0; i < stall; i++) begin
            check_eq("b_stall_valid", BVALID_o, 1);
            check_eq("b_stall_resp", BRESP_o, 2'b00);
            check_eq("b_stall_ready", {ARREADY_o, AWREADY_o, WREADY_o}, 3'b000);
            @(negedge clk_i);
        end
        check_eq("bresp", BRESP_o, 2'b00);
        BREADY_i = 1'b1;
        @(posedge clk_i);
        #1;
        BREADY_i = 1'b0;
        order_q.push_back("W");
        check_eq("b_drop", BVALID_o, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          lat;
        int          cnt0;
        bit          ok;
        bit          rv_seen;
        logic [31:0] a;
        logic [31:0] d;

        rst_i = 1'b1;
        AWADDR_i = '0; AWVALID_i = 1'b0; WDATA_i = '0; WSTRB_i = '0; WVALID_i = 1'b0;
        BREADY_i = 1'b0; ARADDR_i = '0; ARVALID_i = 1'b0; RREADY_i = 1'b0;
        mem[32'h10]    = 32'hDEADBEEF;
        shadow[32'h10] = 32'hDEADBEEF;

        repeat (3) @(negedge clk_i);
        check_eq("rst_handshake", {AWREADY_o, WREADY_o, BVALID_o, ARREADY_o, RVALID_o, mem_valid_o}, 6'b0);
        check_eq("rst_rdata", RDATA_o, 32'h0);
        check_eq("rst_resp", {RRESP_o, BRESP_o}, 4'h0);
        check_eq("rst_mem", {mem_addr_o, mem_wdata_o, mem_wstrb_o}, 68'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Minimum latencies with a zero-wait memory.
        mem_wait = 0;
        do_read(32'h40, shadow_rd(32'h40), 0, 1'b1, lat);
        check_eq("rd_latency", lat, 3);
        do_write(32'h44, 32'hA5A55A5A, 4'hF, 0, 0, 0, 1'b1, lat);
        check_eq("wr_latency", lat, 3);

        // Read with two memory wait states.
        mem_wait = 2;
        do_read(32'h10, 32'hDEADBEEF, 2, 1'b1, lat);

        // W three cycles ahead of AW: exactly one memory write.
        mem_wait = 1;
        cnt0 = mem_done_cnt;
        do_write(32'h20, 32'h12345678, 4'hF, 3, 0, 0, 1'b1, lat);
        check_eq("single_mem_write", mem_done_cnt - cnt0, 1);
        do_read(32'h20, 32'h12345678, 0, 1'b1, lat);

        // AW ahead of W with a partial strobe.
        do_write(32'h24, 32'hCAFEF00D, 4'b0101, 0, 2, 0, 1'b1, lat);
        do_read(32'h24, 32'h00FE000D, 1, 1'b1, lat);

        // All-zero strobe never reaches memory.
        cnt0 = mem_valid_cycles;
        do_write(32'h28, 32'h87654321, 4'h0, 0, 0, 0, 1'b1, lat);
        check_eq("zero_strb_no_mem", mem_valid_cycles - cnt0, 0);

        // Response stalls with a read queued behind a stalled write.
        mem_wait = 0;
        order_q.delete();
        fork
            do_write(32'h30, 32'h0BADCAFE, 4'hF, 0, 0, 5, 1'b1, lat);
            begin
                @(posedge clk_i);
                #1;
                do_read(32'h30, 32'h0BADCAFE, 5, 1'b1, lat);
            end
        join
        check_eq("stall_order_len", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check_eq("stall_order0", order_q[0], "W");
            check_eq("stall_order1", order_q[1], "R");
        end

        // Collision right after reset: write first, then the next collision goes to the read.
        pulse_reset();
        order_q.delete();
        exp_q.push_back({32'h100, 32'h11112222, 4'hF});
        exp_q.push_back({32'h200, 32'h0, 4'h0});
        exp_q.push_back({32'h104, 32'h33334444, 4'hF});
        fork
            begin
                do_write(32'h100, 32'h11112222, 4'hF, 0, 0, 0, 1'b0, lat);
                do_write(32'h104, 32'h33334444, 4'hF, 0, 0, 0, 1'b0, lat);
            end
            do_read(32'h200, shadow_rd(32'h200), 0, 1'b0, lat);
        join
        check_eq("rr_order_len", order_q.size(), 3);
        if (order_q.size() == 3)
            check_eq("rr_order", {order_q[0], order_q[1], order_q[2]}, {"W", "R", "W"});

        // Reset while the memory read is outstanding.
        mem_wait = 50;
        exp_q.push_back({32'h10, 32'h0, 4'h0});
        ARADDR_i  = 32'h10;
        ARVALID_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (ARREADY_o) begin ok = 1'b1; break; end
        end
        check_eq("abort_arready", ok, 1);
        @(posedge clk_i);
        #1;
        ARVALID_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (mem_valid_o) begin ok = 1'b1; break; end
        end
        check_eq("abort_mem_valid_seen", ok, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("abort_mem_valid_async", mem_valid_o, 0);
        check_eq("abort_state", dut.state, 3'd0);
        check_eq("abort_outputs", {ARREADY_o, RVALID_o, BVALID_o, AWREADY_o, WREADY_o}, 5'b0);
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_wait = 0;
        rv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            rv_seen = rv_seen | RVALID_o | mem_valid_o;
        end
        check_eq("abort_no_response", rv_seen, 0);
        @(posedge clk_i);
        #1;

        // Randomised write / read-back pairs.
        for (int n = 0; n < 8; n++) begin
            a = 32'h300 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            d = $urandom;
            mem_wait = $urandom_range(0, 3);
            do_write(a, d, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b1, lat);
            do_read(a, shadow_rd(a), $urandom_range(0, 3), 1'b1, lat);
        end

        repeat (3) @(negedge clk_i);
        check_eq("mem_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
